// File: rtl/bcd_subtractor_seq.sv
// Digit-serial packed-BCD subtractor: D = A - B - bin, one decimal digit per clock, LSD first.
// Negative results come back in ten's-complement form with bout=1; operands with a digit >9 yield d=0, err=1.
module bcd_subtractor_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   d,
  output logic                  bout,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
  logic [KW-1:0]   k_q, k_d;
  logic            br_q, br_d, errn_q, errn_d, bout_q, bout_d, err_q, err_d;
  logic            step_br, last_digit;
  logic [3:0]      step_dig;
  logic [W-1:0]    res_next;

  // One BCD digit step: returns {borrow, digit}; t spans [-16,15] so 5-bit signed suffices.
  function automatic logic [4:0] digit_sub(input logic [3:0] x, input logic [3:0] y,
                                           input logic bi);
    logic signed [4:0] t;
    t = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0000, bi});
    if (t < 0) return {1'b1, 4'(t + 5'sd10)};
    else       return {1'b0, t[3:0]};
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] x);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign {step_br, step_dig} = digit_sub(a_q[3:0], b_q[3:0], br_q);
  assign last_digit          = (k_q == KW'(DIGITS - 1));
  assign res_next            = (res_q >> 4) | (W'(step_dig) << (W - 4));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      k_q     <= '0;
      br_q    <= 1'b0;
      errn_q  <= 1'b0;
      bout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      d_q     <= d_d;
      k_q     <= k_d;
      br_q    <= br_d;
      errn_q  <= errn_d;
      bout_q  <= bout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_digit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operands shift right so the active digit is always in the low nibble.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    d_d    = d_q;
    k_d    = k_q;
    br_d   = br_q;
    errn_d = errn_q;
    bout_d = bout_q;
    err_d  = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          br_d   = bin;
          k_d    = '0;
          res_d  = '0;
          errn_d = has_bad_digit(a) | has_bad_digit(b);
        end
      end
      S_RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        br_d  = step_br;
        res_d = res_next;
        k_d   = k_q + KW'(1);
        if (last_digit) begin
          d_d    = errn_q ? '0   : res_next;
          bout_d = errn_q ? 1'b0 : step_br;
          err_d  = errn_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    d    = d_q;
    bout = bout_q;
    err  = err_q;
  end

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Self-checking bench for bcd_subtractor_seq (DIGITS=4): directed cases plus randomized
// operations compared against an integer-arithmetic reference model.
module tb_bcd_subtractor_seq;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout, err;
  logic [W-1:0] d;

  int checks = 0;
  int passes = 0;

  bcd_subtractor_seq #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: decode BCD to integers, subtract, wrap negatives by 10^DIGITS, re-encode.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] md, output logic mbout, output logic merr);
    int av, bv, diff, pw;
    logic [3:0] na, nb;
    av = 0; bv = 0; pw = 1; merr = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      na = ma[4*i +: 4];
      nb = mb[4*i +: 4];
      if (na > 4'd9 || nb > 4'd9) merr = 1'b1;
      av = av * 10 + int'(na);
      bv = bv * 10 + int'(nb);
      pw = pw * 10;
    end
    md = '0; mbout = 1'b0;
    if (!merr) begin
      diff = av - bv - int'(mbin);
      if (diff < 0) begin
        mbout = 1'b1;
        diff  = diff + pw;
      end
      for (int i = 0; i < DIGITS; i++) begin
        md[4*i +: 4] = 4'(diff % 10);
        diff = diff / 10;
      end
    end
  endfunction

  // Issues one operation from IDLE and reports what was observed; returns once back in IDLE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                        output logic [W-1:0] od, output logic obout, output logic oerr,
                        output int lat, output int busy_cyc, output bit d_moved);
    logic [W-1:0] d_before;
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    d_before = d;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_cyc = 0; d_moved = 1'b0;
    if (busy) busy_cyc++;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = j;
        break;
      end
      if (busy) busy_cyc++;
      if (d !== d_before) d_moved = 1'b1;
    end
    od = d; obout = bout; oerr = err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, d, bout, err} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0})
      $display("FAIL reset_outputs: got busy=%b done=%b d=%h bout=%b err=%b, want all zero",
               busy, done, d, bout, err);
    else passes++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] od; logic ob, oe; int lat, bc; bit mv;
    run_op(16'h0042, 16'h0017, 1'b0, od, ob, oe, lat, bc, mv);
    checks++;
    if (lat !== DIGITS) $display("FAIL basic_latency: got %0d, want %0d", lat, DIGITS);
    else passes++;
    checks++;
    if (bc !== DIGITS) $display("FAIL basic_busy_cycles: got %0d, want %0d", bc, DIGITS);
    else passes++;
    checks++;
    if ({od, ob, oe} !== {16'h0025, 1'b0, 1'b0})
      $display("FAIL basic_result: got d=%h bout=%b err=%b, want d=0025 bout=0 err=0", od, ob, oe);
    else passes++;
    checks++;
    if (mv) $display("FAIL basic_no_glitch: d changed during RUN, want stable");
    else passes++;
    checks++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", done);
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({d, bout, done, busy} !== {16'h0025, 1'b0, 1'b0, 1'b0})
      $display("FAIL idle_hold: got d=%h bout=%b done=%b busy=%b, want d=0025 held", d, bout, done, busy);
    else passes++;
  endtask

  task automatic test_negative();
    logic [W-1:0] od; logic ob, oe; int lat, bc; bit mv;
    run_op(16'h0000, 16'h0001, 1'b0, od, ob, oe, lat, bc, mv);
    checks++;
    if ({od, ob} !== {16'h9999, 1'b1})
      $display("FAIL neg_0_minus_1: got d=%h bout=%b, want d=9999 bout=1", od, ob);
    else passes++;
    run_op(16'h9999, 16'h9999, 1'b1, od, ob, oe, lat, bc, mv);
    checks++;
    if ({od, ob, oe} !== {16'h9999, 1'b1, 1'b0})
      $display("FAIL neg_all9_bin: got d=%h bout=%b err=%b, want d=9999 bout=1 err=0", od, ob, oe);
    else passes++;
    run_op(16'h0000, 16'h0009, 1'b1, od, ob, oe, lat, bc, mv);
    checks++;
    if ({od, ob} !== {16'h9990, 1'b1})
      $display("FAIL neg_t_minus10: got d=%h bout=%b, want d=9990 bout=1", od, ob);
    else passes++;
  endtask

  task automatic test_ripple();
    logic [W-1:0] od; logic ob, oe; int lat, bc; bit mv;
    run_op(16'h1000, 16'h0001, 1'b0, od, ob, oe, lat, bc, mv);
    checks++;
    if ({od, ob} !== {16'h0999, 1'b0})
      $display("FAIL ripple_1000_minus_1: got d=%h bout=%b, want d=0999 bout=0", od, ob);
    else passes++;
    run_op(16'h5000, 16'h5000, 1'b0, od, ob, oe, lat, bc, mv);
    checks++;
    if ({od, ob} !== {16'h0000, 1'b0})
      $display("FAIL ripple_equal: got d=%h bout=%b, want d=0000 bout=0", od, ob);
    else passes++;
  endtask

  task automatic test_err();
    logic [W-1:0] od; logic ob, oe; int lat, bc; bit mv;
    run_op(16'h00A0, 16'h0001, 1'b0, od, ob, oe, lat, bc, mv);
    checks++;
    if (lat !== DIGITS) $display("FAIL err_latency: got %0d, want %0d", lat, DIGITS);
    else passes++;
    checks++;
    if ({od, ob, oe} !== {16'h0000, 1'b0, 1'b1})
      $display("FAIL err_result: got d=%h bout=%b err=%b, want d=0000 bout=0 err=1", od, ob, oe);
    else passes++;
    run_op(16'h0003, 16'h0001, 1'b0, od, ob, oe, lat, bc, mv);
    checks++;
    if ({od, ob, oe} !== {16'h0002, 1'b0, 1'b0})
      $display("FAIL err_recover: got d=%h bout=%b err=%b, want d=0002 bout=0 err=0", od, ob, oe);
    else passes++;
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    a = 16'h0042; b = 16'h0017; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a = 16'h9876; b = 16'h1234; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'h0011; b = 16'h0099;
    lat = -1;
    for (int j = 2; j <= 20; j++) begin
      @(posedge clk); #1;
      if (done) begin lat = j; break; end
    end
    checks++;
    if (lat !== DIGITS) $display("FAIL ignore_latency: got %0d, want %0d", lat, DIGITS);
    else passes++;
    checks++;
    if ({d, bout, err} !== {16'h0025, 1'b0, 1'b0})
      $display("FAIL ignore_result: got d=%h bout=%b err=%b, want d=0025 bout=0 err=0", d, bout, err);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL ignore_not_queued: busy=%b after done, want 0", busy);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int hits[$];
    bit d_ok;
    d_ok = 1'b1;
    @(negedge clk);
    a = 16'h0042; b = 16'h0017; bin = 1'b0; start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) begin
        hits.push_back(c);
        if (d !== 16'h0025) d_ok = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (hits.size() !== 5) $display("FAIL b2b_count: got %0d done pulses, want 5", hits.size());
    else passes++;
    checks++;
    if (hits.size() < 1 || hits[0] !== DIGITS)
      $display("FAIL b2b_first: got first done at %0d, want %0d", (hits.size() > 0) ? hits[0] : -1, DIGITS);
    else passes++;
    for (int i = 1; i < hits.size(); i++) begin
      checks++;
      if (hits[i] - hits[i-1] !== DIGITS + 2)
        $display("FAIL b2b_period: got %0d cycles, want %0d", hits[i] - hits[i-1], DIGITS + 2);
      else passes++;
    end
    checks++;
    if (!d_ok) $display("FAIL b2b_results: got a pulse with d!=0025, want 0025 every time");
    else passes++;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] od; logic ob, oe; int lat, bc; bit mv; bit saw_done;
    @(negedge clk);
    a = 16'h0042; b = 16'h0017; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy, done, d, bout, err} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0})
      $display("FAIL abort_outputs: got busy=%b done=%b d=%h bout=%b err=%b, want all zero",
               busy, done, d, bout, err);
    else passes++;
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) $display("FAIL abort_no_done: got activity after reset, want idle");
    else passes++;
    run_op(16'h0100, 16'h0001, 1'b0, od, ob, oe, lat, bc, mv);
    checks++;
    if ({od, ob, oe, lat} !== {16'h0099, 1'b0, 1'b0, DIGITS})
      $display("FAIL abort_recover: got d=%h bout=%b err=%b lat=%0d, want d=0099 bout=0 err=0 lat=%0d",
               od, ob, oe, lat, DIGITS);
    else passes++;
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, od, ed; logic rbin, ob, oe, eb, ee; int lat, bc; bit mv;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if (n % 8 == 7) ra[4*($urandom_range(0, DIGITS-1)) +: 4] = 4'($urandom_range(10, 15));
      rbin = 1'($urandom_range(0, 1));
      model(ra, rb, rbin, ed, eb, ee);
      run_op(ra, rb, rbin, od, ob, oe, lat, bc, mv);
      checks++;
      if ({od, ob, oe, lat} !== {ed, eb, ee, DIGITS})
        $display("FAIL random_%0d: %h-%h-%b got d=%h bout=%b err=%b lat=%0d, want d=%h bout=%b err=%b lat=%0d",
                 n, ra, rb, rbin, od, ob, oe, lat, ed, eb, ee, DIGITS);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_ripple();
    test_err();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
